// File: rtl/mul_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : mul_reservation_station
// Description : Reservation station in front of the multiplier unit. Holds up
//               to RS_DEPTH dispatched multiplies, snoops the CDB for pending
//               source operands and issues operand-complete entries (lowest
//               index first) over the multiplier's valid/ready issue port.
// Ports       : clk_in, rst_n_in (sync, active-low), flush_in
//               dispatch_*      : dispatch request / ready handshake
//               rs1_* / rs2_*   : operand value, pending flag, producer tag
//               rob_ix_in       : destination ROB index
//               cdb_*           : common data bus broadcast
//               fu_ready_in     : multiplier idle
//               fu_*_out        : registered issue pulse, operands, ROB index
//               occupancy_out   : busy entry count
// Options     : MUL_RS_WAKEUP_BYPASS_EN - an entry completed by the current
//               CDB broadcast may issue in that same cycle, taking the
//               operand straight from cdb_data_in.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_reservation_station #(
  parameter int ROB_IX   = 2,
  parameter int RS_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          flush_in,
  input  logic                          dispatch_valid_in,
  output logic                          dispatch_ready_out,
  input  logic [31:0]                   rs1_val_in,
  input  logic [31:0]                   rs2_val_in,
  input  logic                          rs1_pend_in,
  input  logic                          rs2_pend_in,
  input  logic [ROB_IX:0]               rs1_tag_in,
  input  logic [ROB_IX:0]               rs2_tag_in,
  input  logic [ROB_IX:0]               rob_ix_in,
  input  logic                          cdb_valid_in,
  input  logic [ROB_IX:0]               cdb_rob_ix_in,
  input  logic [31:0]                   cdb_data_in,
  input  logic                          fu_ready_in,
  output logic                          fu_valid_out,
  output logic [31:0]                   fu_rval1_out,
  output logic [31:0]                   fu_rval2_out,
  output logic [ROB_IX:0]               fu_rob_ix_out,
  output logic [$clog2(RS_DEPTH+1)-1:0] occupancy_out
);

  localparam int c_TW = ROB_IX + 1;
  localparam int c_OW = $clog2(RS_DEPTH + 1);
  localparam int c_IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  // Entry storage
  logic              r_busy [RS_DEPTH];
  logic              r_p1   [RS_DEPTH];
  logic              r_p2   [RS_DEPTH];
  logic [31:0]       r_v1   [RS_DEPTH];
  logic [31:0]       r_v2   [RS_DEPTH];
  logic [c_TW-1:0]   r_t1   [RS_DEPTH];
  logic [c_TW-1:0]   r_t2   [RS_DEPTH];
  logic [c_TW-1:0]   r_rob  [RS_DEPTH];

  logic [c_OW-1:0]   r_occ;
  logic              r_fu_valid;
  logic [31:0]       r_fu_v1;
  logic [31:0]       r_fu_v2;
  logic [c_TW-1:0]   r_fu_rob;

  logic [RS_DEPTH-1:0] w_hit1;
  logic [RS_DEPTH-1:0] w_hit2;
  logic [RS_DEPTH-1:0] w_elig;
  logic                w_sel_found;
  logic [c_IW-1:0]     w_sel_idx;
  logic [31:0]         w_iss_v1;
  logic [31:0]         w_iss_v2;
  logic [c_TW-1:0]     w_iss_rob;
  logic [c_IW-1:0]     w_free_idx;
  logic                w_issue;
  logic                w_disp;
  logic                w_cap1;
  logic                w_cap2;

  // Ready-to-dispatch comes from the registered count only, so a same-cycle
  // issue never makes room for a dispatch.
  assign dispatch_ready_out = (r_occ < c_OW'(RS_DEPTH));
  assign w_disp             = dispatch_valid_in && dispatch_ready_out;

  // Operand caught on the CDB in the very cycle it is dispatched
  assign w_cap1 = rs1_pend_in && cdb_valid_in && (cdb_rob_ix_in == rs1_tag_in);
  assign w_cap2 = rs2_pend_in && cdb_valid_in && (cdb_rob_ix_in == rs2_tag_in);

  always_comb begin
    w_hit1 = '0;
    w_hit2 = '0;
    w_elig = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_hit1[i] = r_busy[i] && r_p1[i] && cdb_valid_in && (r_t1[i] == cdb_rob_ix_in);
      w_hit2[i] = r_busy[i] && r_p2[i] && cdb_valid_in && (r_t2[i] == cdb_rob_ix_in);
`ifdef MUL_RS_WAKEUP_BYPASS_EN
      w_elig[i] = r_busy[i] && (!r_p1[i] || w_hit1[i]) && (!r_p2[i] || w_hit2[i]);
`else
      w_elig[i] = r_busy[i] && !r_p1[i] && !r_p2[i];
`endif
    end
  end

  // Priority pick: walk downwards so the lowest index is the final winner.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_iss_v1    = '0;
    w_iss_v2    = '0;
    w_iss_rob   = '0;
    w_free_idx  = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = c_IW'(i);
`ifdef MUL_RS_WAKEUP_BYPASS_EN
        w_iss_v1    = w_hit1[i] ? cdb_data_in : r_v1[i];
        w_iss_v2    = w_hit2[i] ? cdb_data_in : r_v2[i];
`else
        w_iss_v1    = r_v1[i];
        w_iss_v2    = r_v2[i];
`endif
        w_iss_rob   = r_rob[i];
      end
      if (!r_busy[i]) begin
        w_free_idx = c_IW'(i);
      end
    end
  end

  // The registered valid blocks a second issue right after a pulse; this
  // covers the cycle before the multiplier drops its ready.
  assign w_issue = w_sel_found && fu_ready_in && !r_fu_valid;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_busy[i] <= 1'b0;
        r_p1[i]   <= 1'b0;
        r_p2[i]   <= 1'b0;
        r_v1[i]   <= '0;
        r_v2[i]   <= '0;
        r_t1[i]   <= '0;
        r_t2[i]   <= '0;
        r_rob[i]  <= '0;
      end
      r_occ      <= '0;
      r_fu_valid <= 1'b0;
      r_fu_v1    <= '0;
      r_fu_v2    <= '0;
      r_fu_rob   <= '0;
    end else if (flush_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_busy[i] <= 1'b0;
      end
      r_occ      <= '0;
      r_fu_valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (w_hit1[i]) begin
          r_v1[i] <= cdb_data_in;
          r_p1[i] <= 1'b0;
        end
        if (w_hit2[i]) begin
          r_v2[i] <= cdb_data_in;
          r_p2[i] <= 1'b0;
        end
        if (w_issue && (w_sel_idx == c_IW'(i))) begin
          r_busy[i] <= 1'b0;
        end
        // The free slot is never the issuing one, so these cannot collide.
        if (w_disp && (w_free_idx == c_IW'(i))) begin
          r_busy[i] <= 1'b1;
          r_v1[i]   <= w_cap1 ? cdb_data_in : rs1_val_in;
          r_v2[i]   <= w_cap2 ? cdb_data_in : rs2_val_in;
          r_p1[i]   <= rs1_pend_in && !w_cap1;
          r_p2[i]   <= rs2_pend_in && !w_cap2;
          r_t1[i]   <= rs1_tag_in;
          r_t2[i]   <= rs2_tag_in;
          r_rob[i]  <= rob_ix_in;
        end
      end
      r_occ      <= r_occ + c_OW'(w_disp) - c_OW'(w_issue);
      r_fu_valid <= w_issue;
      if (w_issue) begin
        r_fu_v1  <= w_iss_v1;
        r_fu_v2  <= w_iss_v2;
        r_fu_rob <= w_iss_rob;
      end
    end
  end

  assign fu_valid_out  = r_fu_valid;
  assign fu_rval1_out  = r_fu_v1;
  assign fu_rval2_out  = r_fu_v2;
  assign fu_rob_ix_out = r_fu_rob;
  assign occupancy_out = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_mul_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_reservation_station
// Description : Self-checking bench for mul_reservation_station. A behavioural
//               model of the station contents predicts every output each
//               cycle; directed scenarios pin literal values; a randomized
//               phase exercises dispatch/wakeup/issue/flush/reset mixes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_reservation_station;

  localparam int ROB_IX   = 2;
  localparam int RS_DEPTH = 4;
  localparam int TW       = ROB_IX + 1;
  localparam int OW       = $clog2(RS_DEPTH + 1);
`ifdef MUL_RS_WAKEUP_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, disp_v, disp_rdy;
  logic [31:0]   rs1_val, rs2_val;
  logic          rs1_pend, rs2_pend;
  logic [TW-1:0] rs1_tag, rs2_tag, rob_ix;
  logic          cdb_v;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_data;
  logic          fu_rdy, fu_v;
  logic [31:0]   fu_r1, fu_r2;
  logic [TW-1:0] fu_rob;
  logic [OW-1:0] occ;

  mul_reservation_station #(.ROB_IX(ROB_IX), .RS_DEPTH(RS_DEPTH)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
    .dispatch_valid_in(disp_v), .dispatch_ready_out(disp_rdy),
    .rs1_val_in(rs1_val), .rs2_val_in(rs2_val),
    .rs1_pend_in(rs1_pend), .rs2_pend_in(rs2_pend),
    .rs1_tag_in(rs1_tag), .rs2_tag_in(rs2_tag), .rob_ix_in(rob_ix),
    .cdb_valid_in(cdb_v), .cdb_rob_ix_in(cdb_tag), .cdb_data_in(cdb_data),
    .fu_ready_in(fu_rdy), .fu_valid_out(fu_v),
    .fu_rval1_out(fu_r1), .fu_rval2_out(fu_r2), .fu_rob_ix_out(fu_rob),
    .occupancy_out(occ)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          busy;
    bit          p1, p2;
    bit [31:0]   v1, v2;
    bit [TW-1:0] t1, t2, rob;
  } ent_t;

  ent_t        m_e [RS_DEPTH];
  ent_t        m_d;
  bit          m_valid = 1'b0;
  bit [31:0]   m_r1, m_r2;
  bit [TW-1:0] m_rob;
  bit          started = 1'b0;
  bit          prev_v  = 1'b0;
  int          m_n, m_sel, m_fr;

  function automatic bit avail(input bit p, input bit [TW-1:0] t);
    return !p || (c_BYP && cdb_v && (t == cdb_tag));
  endfunction

  function automatic int busy_count();
    int c = 0;
    for (int i = 0; i < RS_DEPTH; i++) if (m_e[i].busy) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) m_e[i] = '{default: '0};
      m_valid = 1'b0; m_r1 = '0; m_r2 = '0; m_rob = '0;
    end else if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) m_e[i].busy = 1'b0;
      m_valid = 1'b0;
    end else begin
      m_n = busy_count(); m_sel = -1; m_fr = -1;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (!m_e[i].busy && m_fr < 0) m_fr = i;
        if (m_sel < 0 && m_e[i].busy && avail(m_e[i].p1, m_e[i].t1) && avail(m_e[i].p2, m_e[i].t2))
          m_sel = i;
      end
      if (m_sel >= 0 && fu_rdy && !m_valid) begin
        m_r1  = m_e[m_sel].p1 ? cdb_data : m_e[m_sel].v1;
        m_r2  = m_e[m_sel].p2 ? cdb_data : m_e[m_sel].v2;
        m_rob = m_e[m_sel].rob;
        m_e[m_sel].busy = 1'b0;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (m_e[i].busy && cdb_v && m_e[i].p1 && m_e[i].t1 == cdb_tag) begin m_e[i].v1 = cdb_data; m_e[i].p1 = 0; end
        if (m_e[i].busy && cdb_v && m_e[i].p2 && m_e[i].t2 == cdb_tag) begin m_e[i].v2 = cdb_data; m_e[i].p2 = 0; end
      end
      if (disp_v && m_n < RS_DEPTH) begin
        m_d.busy = 1'b1; m_d.rob = rob_ix; m_d.t1 = rs1_tag; m_d.t2 = rs2_tag;
        m_d.p1 = rs1_pend && !(cdb_v && cdb_tag == rs1_tag);
        m_d.p2 = rs2_pend && !(cdb_v && cdb_tag == rs2_tag);
        m_d.v1 = (rs1_pend && !m_d.p1) ? cdb_data : rs1_val;
        m_d.v2 = (rs2_pend && !m_d.p2) ? cdb_data : rs2_val;
        m_e[m_fr] = m_d;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      check("dispatch_ready", {31'b0, disp_rdy}, {31'b0, busy_count() < RS_DEPTH});
      check("occupancy", {{(32-OW){1'b0}}, occ}, busy_count());
      check("fu_valid", {31'b0, fu_v}, {31'b0, m_valid});
      if (m_valid) begin
        check("fu_rval1", fu_r1, m_r1);
        check("fu_rval2", fu_r2, m_r2);
        check("fu_rob_ix", {{(32-TW){1'b0}}, fu_rob}, {{(32-TW){1'b0}}, m_rob});
      end
      check("no_back_to_back", {31'b0, prev_v & fu_v}, 32'd0);
      prev_v = fu_v;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    flush = 0; disp_v = 0; cdb_v = 0; cdb_tag = '0; cdb_data = '0;
    rs1_val = '0; rs2_val = '0; rs1_pend = 0; rs2_pend = 0;
    rs1_tag = '0; rs2_tag = '0; rob_ix = '0;
  endtask

  task automatic drive_disp(input logic [31:0] v1, input logic p1, input logic [TW-1:0] t1,
                            input logic [31:0] v2, input logic p2, input logic [TW-1:0] t2,
                            input logic [TW-1:0] rob);
    disp_v = 1; rs1_val = v1; rs1_pend = p1; rs1_tag = t1;
    rs2_val = v2; rs2_pend = p2; rs2_tag = t2; rob_ix = rob;
  endtask

  initial begin
    set_idle(); rst_n = 0; fu_rdy = 0;
    repeat (3) @(negedge clk);
    check("reset_occupancy", {29'b0, occ}, 0);
    check("reset_fu_valid", {31'b0, fu_v}, 0);
    check("reset_rval1", fu_r1, 0);
    check("reset_rval2", fu_r2, 0);
    check("reset_rob", {29'b0, fu_rob}, 0);
    check("reset_dispatch_ready", {31'b0, disp_rdy}, 1);
    rst_n = 1; fu_rdy = 1;
    @(negedge clk);

    // Operand-complete dispatch -> pulse two cycles later
    drive_disp(7, 0, 0, 6, 0, 0, 3);
    @(negedge clk); set_idle();
    check("t1_not_yet", {31'b0, fu_v}, 0);
    check("t1_occ_1", {29'b0, occ}, 1);
    @(negedge clk);
    check("t1_valid", {31'b0, fu_v}, 1);
    check("t1_rval1", fu_r1, 7);
    check("t1_rval2", fu_r2, 6);
    check("t1_rob", {29'b0, fu_rob}, 3);
    check("t1_occ_0", {29'b0, occ}, 0);
    @(negedge clk);
    check("t1_single_pulse", {31'b0, fu_v}, 0);

    // Pending rs1 woken by CDB three cycles after dispatch
    drive_disp(0, 1, 5, 2, 0, 0, 1);
    @(negedge clk); set_idle();
    @(negedge clk); @(negedge clk);
    cdb_v = 1; cdb_tag = 5; cdb_data = 32'hFFFF_FFFC;
    @(negedge clk); set_idle();
    if (!c_BYP) @(negedge clk);
    check("t2_valid", {31'b0, fu_v}, 1);
    check("t2_rval1", fu_r1, 32'hFFFF_FFFC);
    check("t2_rval2", fu_r2, 2);
    check("t2_rob", {29'b0, fu_rob}, 1);
    @(negedge clk);
    check("t2_single_pulse", {31'b0, fu_v}, 0);

    // Fill the station, fifth dispatch ignored, then drain in index order
    fu_rdy = 0;
    for (int k = 0; k < 4; k++) begin
      drive_disp(100 + k, 0, 0, 200 + k, 0, 0, TW'(k));
      @(negedge clk);
    end
    check("fill_not_ready", {31'b0, disp_rdy}, 0);
    check("fill_occ", {29'b0, occ}, 4);
    drive_disp(999, 0, 0, 999, 0, 0, 7);
    @(negedge clk); set_idle();
    check("full_occ", {29'b0, occ}, 4);
    fu_rdy = 1;
    @(negedge clk);
    check("drain_valid", {31'b0, fu_v}, 1);
    check("drain_first_rob", {29'b0, fu_rob}, 0);
    check("drain_first_rval1", fu_r1, 100);
    check("drain_ready_again", {31'b0, disp_rdy}, 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("drain_gap", {31'b0, fu_v}, 0);
      @(negedge clk);
      check("drain_valid", {31'b0, fu_v}, 1);
      check("drain_rob", {29'b0, fu_rob}, k);
      check("drain_rval2", fu_r2, 200 + k);
    end
    @(negedge clk);
    check("drain_empty", {29'b0, occ}, 0);

    // Dispatch-time capture from a same-cycle broadcast
    drive_disp(3, 0, 0, 0, 1, 1, 2);
    cdb_v = 1; cdb_tag = 1; cdb_data = 9;
    @(negedge clk); set_idle();
    check("t4_not_yet", {31'b0, fu_v}, 0);
    @(negedge clk);
    check("t4_valid", {31'b0, fu_v}, 1);
    check("t4_rval1", fu_r1, 3);
    check("t4_rval2", fu_r2, 9);
    check("t4_rob", {29'b0, fu_rob}, 2);

    // Two ready entries with ready held high: pulses alternate
    @(negedge clk);
    fu_rdy = 0;
    drive_disp(11, 0, 0, 12, 0, 0, 4);
    @(negedge clk);
    drive_disp(21, 0, 0, 22, 0, 0, 5);
    @(negedge clk); set_idle(); fu_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_pattern", {31'b0, fu_v}, {31'b0, (k % 2) == 0});
    end

    // Flush, then reset, with three entries busy and a dispatch in flight
    for (int run = 0; run < 2; run++) begin
      fu_rdy = 0;
      for (int k = 0; k < 3; k++) begin
        drive_disp(50 + k, 0, 0, 60 + k, 0, 0, TW'(k));
        @(negedge clk);
      end
      check("t6_occ_3", {29'b0, occ}, 3);
      drive_disp(77, 0, 0, 78, 0, 0, 6);
      cdb_v = 1; cdb_tag = 0; cdb_data = 5; fu_rdy = 1;
      if (run == 0) flush = 1; else rst_n = 0;
      @(negedge clk); set_idle(); rst_n = 1;
      check("t6_occ_0", {29'b0, occ}, 0);
      check("t6_ready", {31'b0, disp_rdy}, 1);
      check("t6_no_valid", {31'b0, fu_v}, 0);
      repeat (4) begin
        @(negedge clk);
        check("t6_quiet", {31'b0, fu_v}, 0);
      end
    end

    // Randomized mix
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n    = ($urandom_range(0, 199) != 0);
      flush    = ($urandom_range(0, 49) == 0);
      fu_rdy   = ($urandom_range(0, 9) < 7);
      disp_v   = ($urandom_range(0, 1) == 1);
      rs1_val  = 32'($urandom);
      rs2_val  = 32'($urandom);
      rs1_pend = ($urandom_range(0, 9) < 4);
      rs2_pend = ($urandom_range(0, 9) < 4);
      rs1_tag  = TW'($urandom_range(0, 7));
      rs2_tag  = TW'($urandom_range(0, 7));
      rob_ix   = TW'($urandom_range(0, 7));
      cdb_v    = ($urandom_range(0, 1) == 1);
      cdb_tag  = TW'($urandom_range(0, 7));
      cdb_data = 32'($urandom);
    end
    @(negedge clk); set_idle(); rst_n = 1; fu_rdy = 1;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_reservation_station.md
# mul_reservation_station

Reservation station in front of the multiplier functional unit. Holds up to RS_DEPTH dispatched multiply instructions, snoops the common data bus (CDB) for pending source operands, and issues operand-complete entries to the multiplier over its valid/ready issue port. It is the initiator side of the multiplier's issue protocol: it drives the unit's valid, operand and ROB-index inputs and honours its ready output.

## Interface
- ROB_IX, 2, ROB index MSB; tags and ROB indices are ROB_IX+1 bits
- RS_DEPTH, 4, number of entries (≥2)
- clk_in  input  1  clock; all logic on rising edge; one clock domain
- rst_n_in  input  1  reset, synchronous, active-low
- flush_in  input  1  squash all entries (mispredict)
- dispatch_valid_in  input  1  dispatch request this cycle
- dispatch_ready_out  output  1  station can accept a dispatch
- rs1_val_in / rs2_val_in  input  32 each  operand value when not pending
- rs1_pend_in / rs2_pend_in  input  1 each  operand still being produced
- rs1_tag_in / rs2_tag_in  input  ROB_IX+1 each  producer ROB index when pending
- rob_ix_in  input  ROB_IX+1  destination ROB index of dispatched op
- cdb_valid_in  input  1  CDB broadcast valid
- cdb_rob_ix_in  input  ROB_IX+1  producer tag on CDB
- cdb_data_in  input  32  result on CDB
- fu_ready_in  input  1  multiplier idle (its ready output)
- fu_valid_out  output  1  issue pulse, one cycle per issued op
- fu_rval1_out / fu_rval2_out  output  32 each  operands to multiplier
- fu_rob_ix_out  output  ROB_IX+1  ROB index to multiplier
- occupancy_out  output  $clog2(RS_DEPTH+1)  busy entry count

## Operation
- Per entry: busy, v1/v2 (32b), p1/p2 pending flags, t1/t2 tags, rob_ix.
- Dispatch: accepted when dispatch_valid_in && dispatch_ready_out; written into lowest-index free entry. dispatch_ready_out = occupancy < RS_DEPTH, from registered state only (an issue in the same cycle does not free a slot for that cycle's dispatch).
- Dispatch-time capture: if rsN_pend_in and cdb_valid_in and cdb_rob_ix_in == rsN_tag_in in the same cycle, entry stores cdb_data_in with pN=0.
- Wakeup: each cycle, every busy entry with pN=1 and tN == cdb_rob_ix_in under cdb_valid_in loads cdb_data_in into vN, clears pN. Both operands may wake from one broadcast.
- Ready entry: busy && !p1 && !p2 (registered state).
- Issue select: lowest-index ready entry. Issue fires when a ready entry exists, fu_ready_in=1 and fu_valid_out=0 (lockout covers the cycle before the multiplier's ready deasserts). On issue: entry busy cleared; fu_valid_out, fu_rval1_out, fu_rval2_out, fu_rob_ix_out registered, valid next cycle.
- Operand values are passed unmodified; no arithmetic performed.
- Flush: all busy cleared, fu_valid_out forced 0 next cycle; dispatch and CDB in a flush cycle are ignored. Flush dominates dispatch, wakeup and issue.

## Timing
- Reset (rst_n_in=0 at edge): all busy=0, fu_valid_out=0, fu_rval1_out=0, fu_rval2_out=0, fu_rob_ix_out=0, occupancy_out=0; dispatch_ready_out=1 after reset.
- Dispatch of operand-complete op at cycle t: eligible at t+1, fu_valid_out high at t+2 (given fu_ready_in).
- CDB wakeup at cycle t: eligible at t+1, fu_valid_out at t+2.
- fu_valid_out never high two consecutive cycles.
- occupancy_out updates one cycle after dispatch/issue; simultaneous dispatch+issue leaves it unchanged.
- Reset mid-operation discards all entries; no issue pulse follows.

## Configuration
- MUL_RS_WAKEUP_BYPASS_EN defined: an entry whose last pending operand matches the CDB in cycle t is eligible in cycle t itself, using cdb_data_in as the operand output; wakeup-to-fu_valid_out latency drops to 1 cycle (fu_valid_out at t+1). Lowest-index priority still applies across registered-ready and bypass-ready entries.
- Undefined: wakeup-to-issue latency is 2 cycles as in Timing.

## Test plan
- Reset then dispatch rs1=7, rs2=6, rob_ix=3, both not pending, fu_ready_in=1 -> fu_valid_out pulse 2 cycles later with fu_rval1_out=7, fu_rval2_out=6, fu_rob_ix_out=3; occupancy back to 0.
- Dispatch rs1 pending tag 5, rs2=2; 3 cycles later CDB tag 5 data -4 -> issue with fu_rval1_out=-4 (0xFFFFFFFC), fu_rval2_out=2, 2 cycles after broadcast (1 cycle with MUL_RS_WAKEUP_BYPASS_EN).
- Fill 4 entries with fu_ready_in=0 -> dispatch_ready_out=0, 5th dispatch ignored; raise fu_ready_in -> entry 0 issues first, dispatch_ready_out returns 1 next cycle.
- Dispatch with rs2 pending tag 1 while CDB broadcasts tag 1 data 9 in the same cycle -> entry stores 9, issues without further broadcast.
- Hold fu_ready_in=1 with 2 ready entries -> fu_valid_out pulses separated by ≥1 idle cycle, never back-to-back.
- Three entries busy, assert flush_in (also rst_n_in=0 in a second run) with dispatch_valid_in=1 -> occupancy_out=0, no fu_valid_out afterwards, dispatch_ready_out=1.
